// File: rtl/fifo_thresholds_pkg.sv
// Shared defaults for the lane FIFOs that surround the round-robin arbiter.
package fifo_thresholds_pkg;
  localparam int FT_DATA_WIDTH = 6;
  localparam int FT_ADDR_WIDTH = 3;
  localparam int FT_AF_LEVEL   = 6;
  localparam int FT_AE_LEVEL   = 2;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: registered write port, asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately left uninitialised; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_thresholds.sv
// Single-clock FWFT FIFO with almost-full/almost-empty thresholds and a sticky
// overflow/underflow flag. All outputs decode from registered state only.
module fifo_thresholds
  import fifo_thresholds_pkg::*;
#(
  parameter int DATA_WIDTH = FT_DATA_WIDTH,
  parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
  parameter int AF_LEVEL   = FT_AF_LEVEL,
  parameter int AE_LEVEL   = FT_AE_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] rdata;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign error        = error_q;
  assign count        = count_q;

  // A push into a full FIFO is fine when a pop frees the slot in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    if ((push && full && !pop) || (pop && empty)) error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_ok && !reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign data_out = empty ? '0 : rdata;
endmodule
